// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder: MODE bit positions,
// synchroniser depth and the frame-control FSM states.
package spi_pkg;

    localparam int CPOL_BIT    = 1;
    localparam int CPHA_BIT    = 0;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        WAIT_CS_HIGH,
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a registered change
// detector; the consumer decodes rise/fall from level_o and toggle_o.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic toggle_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o  = sync_q[SYNC_STAGES-1];
    assign toggle_o = level_o ^ prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder oversampling SCK/CS/MOSI on clk: MSB-first DATA_W-bit words,
// back-to-back words per frame, single-entry TX buffer and pulsed RX port.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [1:0] MODE   = 2'b00,
    parameter int         DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam logic CPOL       = MODE[CPOL_BIT];
    localparam logic CPHA       = MODE[CPHA_BIT];
    // Sample edge leaves SCK high for modes 0 and 3, low for modes 1 and 2.
    localparam logic SAMPLE_LVL = ~(CPOL ^ CPHA);
    localparam int   CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam int   SETTLE_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

    logic sck_s, sck_tgl, cs_s, cs_tgl, mosi_s;
    logic sample_edge, shift_edge, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, buf_q, buf_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                skip_q, skip_d, load_pend_q, load_pend_d;
    logic                buf_full_q, buf_full_d;
    logic                load, tx_write, underrun_d, rx_done_d;
    logic                miso_q, oe_q, rx_done_q, rx_valid_q, underrun_q;
    logic [DATA_W-1:0]   rx_data_q;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
        .clk(clk), .rst(rst), .d_i(sck), .level_o(sck_s), .toggle_o(sck_tgl)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d_i(cs), .level_o(cs_s), .toggle_o(cs_tgl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = sck_tgl && (sck_s == SAMPLE_LVL);
    assign shift_edge  = sck_tgl && (sck_s != SAMPLE_LVL);
    assign cs_rise     = cs_tgl && cs_s;
    assign cs_fall     = cs_tgl && !cs_s;

    always_comb begin
        state_d     = state_q;
        settle_d    = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 1'b1;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        skip_d      = skip_q;
        load_pend_d = load_pend_q;
        load        = 1'b0;
        rx_done_d   = 1'b0;
        case (state_q)
            // The synchronisers come out of reset showing CS high, so the
            // level is trusted only once the pin has propagated through them.
            WAIT_CS_HIGH: if (settle_q == SETTLE_DONE && cs_s) state_d = IDLE;
            IDLE: begin
                if (cs_fall) begin
                    state_d     = SHIFT;
                    load        = 1'b1;
                    bit_cnt_d   = '0;
                    skip_d      = CPHA;
                    load_pend_d = 1'b0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = '0;
                        rx_done_d   = 1'b1;
                        load_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (load_pend_q) begin
                        load        = 1'b1;
                        load_pend_d = 1'b0;
                    end else if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            default: state_d = WAIT_CS_HIGH;
        endcase

        // A load always sees the buffer as it was before this cycle's write.
        underrun_d = load && !buf_full_q;
        if (load) tx_sr_d = buf_full_q ? buf_q : '0;
        tx_write   = tx_valid && !buf_full_q;
        buf_d      = tx_write ? tx_data : buf_q;
        buf_full_d = (buf_full_q && !load) || tx_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_CS_HIGH;
            settle_q    <= '0;
            tx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            skip_q      <= 1'b0;
            load_pend_q <= 1'b0;
            buf_full_q  <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            tx_sr_q     <= tx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            skip_q      <= skip_d;
            load_pend_q <= load_pend_d;
            buf_full_q  <= buf_full_d;
            miso_q      <= tx_sr_q[DATA_W-1];
            oe_q        <= (state_q == SHIFT);
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_done_q;
            underrun_q  <= underrun_d;
            if (rx_done_q) rx_data_q <= rx_sr_q;
        end
    end

    always_ff @(posedge clk) begin
        rx_sr_q <= rx_sr_d;
        buf_q   <= buf_d;
    end

    assign miso        = miso_q;
    assign miso_oe     = oe_q;
    assign tx_ready    = !buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode on a shared SCK/MOSI
// bus, a behavioural SPI master, and table-driven plus hand-written frames.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst, sck, mosi;
    logic [3:0]  cs, txv;
    logic [63:0] txd;
    logic [3:0]  miso_w, oe_w, txr_w, rxv_w, und_w, busy_w;
    logic [7:0]  rx0, rx1, rx3;
    logic [63:0] rx2;
    logic [1:0]  sel;

    logic        cur_miso, cur_oe, cur_txr, cur_rxv, cur_und, cur_busy;
    logic [63:0] cur_rx;

    always #5 clk = ~clk;

    spi_slave #(.MODE(2'b00), .DATA_W(8)) u0 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs[0]), .mosi(mosi), .miso(miso_w[0]),
        .miso_oe(oe_w[0]), .tx_data(txd[7:0]), .tx_valid(txv[0]), .tx_ready(txr_w[0]),
        .rx_data(rx0), .rx_valid(rxv_w[0]), .tx_underrun(und_w[0]), .busy(busy_w[0]));
    spi_slave #(.MODE(2'b01), .DATA_W(8)) u1 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs[1]), .mosi(mosi), .miso(miso_w[1]),
        .miso_oe(oe_w[1]), .tx_data(txd[7:0]), .tx_valid(txv[1]), .tx_ready(txr_w[1]),
        .rx_data(rx1), .rx_valid(rxv_w[1]), .tx_underrun(und_w[1]), .busy(busy_w[1]));
    spi_slave #(.MODE(2'b10), .DATA_W(64)) u2 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs[2]), .mosi(mosi), .miso(miso_w[2]),
        .miso_oe(oe_w[2]), .tx_data(txd), .tx_valid(txv[2]), .tx_ready(txr_w[2]),
        .rx_data(rx2), .rx_valid(rxv_w[2]), .tx_underrun(und_w[2]), .busy(busy_w[2]));
    spi_slave #(.MODE(2'b11), .DATA_W(8)) u3 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs[3]), .mosi(mosi), .miso(miso_w[3]),
        .miso_oe(oe_w[3]), .tx_data(txd[7:0]), .tx_valid(txv[3]), .tx_ready(txr_w[3]),
        .rx_data(rx3), .rx_valid(rxv_w[3]), .tx_underrun(und_w[3]), .busy(busy_w[3]));

    always_comb begin
        cur_miso = miso_w[sel];
        cur_oe   = oe_w[sel];
        cur_txr  = txr_w[sel];
        cur_rxv  = rxv_w[sel];
        cur_und  = und_w[sel];
        cur_busy = busy_w[sel];
        case (sel)
            2'd0:    cur_rx = {56'd0, rx0};
            2'd1:    cur_rx = {56'd0, rx1};
            2'd2:    cur_rx = rx2;
            default: cur_rx = {56'd0, rx3};
        endcase
    end

    // TX feeder: words queued by the test go into the selected DUT whenever it is ready.
    logic [63:0] tx_words [64];
    int          wr_idx = 0;
    int          rd_idx = 0;

    always @(negedge clk) begin
        txv = '0;
        if (!rst && rd_idx < wr_idx && cur_txr) begin
            txd      = tx_words[rd_idx];
            txv[sel] = 1'b1;
            rd_idx++;
        end
    end

    // Receive monitor.
    logic [63:0] rx_log [$];
    int          ur_cnt = 0;

    always @(negedge clk) begin
        if (cur_rxv) rx_log.push_back(cur_rx);
        if (cur_und) ur_cnt++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [63:0] w);
        tx_words[wr_idx] = w;
        wr_idx++;
    endtask

    // Master: SCK half period 4 clk, MISO captured just before each sample edge.
    task automatic spi_bits(input logic [1:0] mode, input int n, input logic [127:0] mo,
                            output logic [127:0] mi);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        mi   = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                tick(4);
                mi  = {mi[126:0], cur_miso};
                sck = ~cpol;
                tick(4);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[i];
                tick(4);
                mi  = {mi[126:0], cur_miso};
                sck = cpol;
                tick(4);
            end
        end
    endtask

    task automatic frame_start(input logic [1:0] mode);
        sck = mode[1];
        tick(4);
        cs[sel] = 1'b0;
        tick(4);
    endtask

    task automatic frame_end;
        tick(4);
        cs[sel] = 1'b1;
        tick(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"},        64'(cur_miso), 64'd0);
        check({tag, " miso_oe"},     64'(cur_oe),   64'd0);
        check({tag, " tx_ready"},    64'(cur_txr),  64'd1);
        check({tag, " rx_data"},     cur_rx,        64'd0);
        check({tag, " rx_valid"},    64'(cur_rxv),  64'd0);
        check({tag, " tx_underrun"}, 64'(cur_und),  64'd0);
        check({tag, " busy"},        64'(cur_busy), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  dut;
        logic [1:0]  mode;
        int          w;
        bit          has_tx;
        logic [63:0] tx_word;
        logic [63:0] mo;
        logic [63:0] exp_rx;
        logic [63:0] exp_mi;
        int          exp_ur;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] mi;
        logic [63:0]  mask;
        int           rx_base, ur_base;

        vecs[0] = '{2'd0, 2'b00, 8,  1'b1, 64'hA5, 64'h3C, 64'h3C, 64'hA5, 0};
        vecs[1] = '{2'd1, 2'b01, 8,  1'b0, 64'h00, 64'h96, 64'h96, 64'h00, 1};
        vecs[2] = '{2'd2, 2'b10, 64, 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF,
                    64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0};
        vecs[3] = '{2'd0, 2'b00, 8,  1'b1, 64'hC3, 64'h81, 64'h81, 64'hC3, 0};
        vecs[4] = '{2'd1, 2'b01, 8,  1'b1, 64'h7E, 64'hE7, 64'hE7, 64'h7E, 0};
        vecs[5] = '{2'd3, 2'b11, 8,  1'b1, 64'h01, 64'h80, 64'h80, 64'h01, 0};

        sel  = 2'd0;
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cs   = 4'hF;
        txv  = '0;
        txd  = '0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(6);
        check("idle busy", 64'(cur_busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].dut;
            if (vecs[i].has_tx) begin
                push_tx(vecs[i].tx_word);
                // CPHA=0 reloads on the trailing edge after the last bit; give it a word.
                if (!vecs[i].mode[0]) push_tx(64'd0);
            end
            tick(4);
            rx_base = rx_log.size();
            ur_base = ur_cnt;
            frame_start(vecs[i].mode);
            check($sformatf("v%0d busy in frame", i), 64'(cur_busy), 64'd1);
            check($sformatf("v%0d miso_oe in frame", i), 64'(cur_oe), 64'd1);
            spi_bits(vecs[i].mode, vecs[i].w, {64'd0, vecs[i].mo}, mi);
            frame_end();
            mask = (vecs[i].w == 64) ? '1 : ((64'd1 << vecs[i].w) - 64'd1);
            check($sformatf("v%0d rx_valid count", i), 64'(rx_log.size() - rx_base), 64'd1);
            if (rx_log.size() > rx_base)
                check($sformatf("v%0d rx_data", i), rx_log[rx_base], vecs[i].exp_rx);
            check($sformatf("v%0d master capture", i), mi[63:0] & mask, vecs[i].exp_mi);
            check($sformatf("v%0d underrun count", i), 64'(ur_cnt - ur_base), 64'(vecs[i].exp_ur));
            check($sformatf("v%0d miso_oe after", i), 64'(cur_oe), 64'd0);
        end

        // Two words in one frame, second word written once tx_ready returns.
        sel = 2'd3;
        push_tx(64'h55);
        push_tx(64'hAA);
        tick(4);
        rx_base = rx_log.size();
        ur_base = ur_cnt;
        frame_start(2'b11);
        spi_bits(2'b11, 16, 128'h1234, mi);
        frame_end();
        check("two-word rx count", 64'(rx_log.size() - rx_base), 64'd2);
        if (rx_log.size() >= rx_base + 2) begin
            check("two-word rx first", rx_log[rx_base], 64'h12);
            check("two-word rx second", rx_log[rx_base+1], 64'h34);
        end
        check("two-word master capture", 64'(mi[15:0]), 64'h55AA);
        check("two-word underrun", 64'(ur_cnt - ur_base), 64'd0);

        // Aborted word after 5 bits, then a complete frame.
        sel = 2'd0;
        tick(4);
        rx_base = rx_log.size();
        frame_start(2'b00);
        spi_bits(2'b00, 5, 128'h15, mi);
        frame_end();
        check("abort no rx_valid", 64'(rx_log.size() - rx_base), 64'd0);
        frame_start(2'b00);
        spi_bits(2'b00, 8, 128'hF0, mi);
        frame_end();
        check("after abort rx count", 64'(rx_log.size() - rx_base), 64'd1);
        if (rx_log.size() > rx_base)
            check("after abort rx_data", rx_log[rx_base], 64'hF0);

        // Reset mid-frame with CS held low; the rest of that frame is ignored.
        frame_start(2'b00);
        spi_bits(2'b00, 3, 128'h5, mi);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-frame reset");
        tick(2);
        rst = 1'b0;
        rx_base = rx_log.size();
        spi_bits(2'b00, 5, 128'h1F, mi);
        check("post-reset busy with cs low", 64'(cur_busy), 64'd0);
        frame_end();
        check("post-reset no rx", 64'(rx_log.size() - rx_base), 64'd0);
        frame_start(2'b00);
        spi_bits(2'b00, 8, 128'h5A, mi);
        frame_end();
        check("post-reset rx count", 64'(rx_log.size() - rx_base), 64'd1);
        if (rx_log.size() > rx_base)
            check("post-reset rx_data", rx_log[rx_base], 64'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the SPI master path: receives MOSI words and returns MISO words to a single external master. It is fully synchronous to a local system clock that oversamples SCK/CS/MOSI, with CPOL/CPHA selectable by parameter. Each word is MSB-first and `DATA_W` bits wide. Multiple back-to-back words per CS-low frame are supported. It sits at the device side of a board-to-board or FPGA-to-FPGA SPI link and feeds user logic through a valid/ready transmit port and a pulse-qualified receive port.

## Interface
- `MODE`, 2'b00, SPI mode; bit1 = CPOL, bit0 = CPHA.
- `DATA_W`, 8, word width in bits, legal range 2..64.
- `clk`  in  1  system clock, ≥ 8× SCK frequency.
- `rst`  in  1  reset, asynchronous, active-high.
- `sck`  in  1  SPI clock from the master, asynchronous to `clk`.
- `cs`  in  1  chip select, active-low, asynchronous.
- `mosi`  in  1  master-out data.
- `miso`  out  1  slave-out data.
- `miso_oe`  out  1  high while the frame is active; enable for an external tristate buffer.
- `tx_data`  in  DATA_W  next word to return to the master.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  single-entry TX buffer is empty.
- `rx_data`  out  DATA_W  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-`clk` pulse when `rx_data` updates.
- `tx_underrun`  out  1  one-`clk` pulse when a word load finds the TX buffer empty.
- `busy`  out  1  high in state SHIFT.

## Operation
- **Synchronisation:** `sck`, `cs` and `mosi` each pass through 2 flip-flops. Registered edge detection runs on synchronised `sck`/`cs`. Synchronisers reset to `sck`=CPOL, `cs`=1, `mosi`=0.
- **Edge selection:**
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
- **FSM:** WAIT_CS_HIGH (reset state) -> IDLE when synchronised `cs`=1. IDLE -> SHIFT on `cs` falling edge. SHIFT -> IDLE on `cs` rising edge. The reset state prevents starting mid-frame if `cs` is low when reset is released.
- **Frame start (IDLE -> SHIFT):**
  - `tx_sr` is loaded from the TX buffer, or with all zeros plus a `tx_underrun` pulse if the buffer is empty.
  - `bit_cnt` = 0; `skip_shift` = CPHA; `load_pending` = 0.
- **MISO drive:** `miso` = `tx_sr[DATA_W-1]`, registered.
- **Sample edge (SHIFT only):**
  - `rx_sr` <= {`rx_sr[DATA_W-2:0]`, `mosi_s`}; `bit_cnt`++.
  - At `bit_cnt` = DATA_W-1: the assembled word goes to `rx_data`, `rx_valid` pulses, `bit_cnt` wraps to 0, and `load_pending` is set.
- **Shift edge (SHIFT only), in priority order:**
  - if `load_pending`: load `tx_sr` from the buffer (zero plus underrun if empty) and clear the flag;
  - else if `skip_shift`: clear it;
  - else: shift `tx_sr` left by one.
- **TX buffer:** writes on `tx_valid && tx_ready` and empties on every load.
  - Write and load in the same cycle: the load sees the old, empty buffer and flags underrun. The written word is kept for the next load.
- **Abort:** `cs` rising with `bit_cnt` ≠ 0 discards the partial word. There is no `rx_valid`, and the TX buffer is untouched.
- **Priority:** `cs` edges take precedence over `sck` edges detected in the same cycle. `sck` edges are ignored outside SHIFT.
- **Arithmetic:** `bit_cnt` is $clog2(DATA_W) bits wide and never exceeds DATA_W-1.

## Timing
- **Reset values:** `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0, state WAIT_CS_HIGH.
- **Input latency:** a pin edge is acted on 3 `clk` after it reaches the synchroniser (2 sync stages + 1 edge register).
- **`rx_valid`:** asserts 4 `clk` after the final sample edge at the pin. It is high for exactly 1 `clk`.
- **`miso`:** updates 4 `clk` after a shift edge, or 4 `clk` after the `cs` fall for the first bit.
- **SCK limits:** SCK high and low phases must each be ≥ 4 `clk`. CS-to-first-SCK-edge must be ≥ 4 `clk`.
- **`miso_oe`:** rises/falls 4 `clk` after the `cs` fall/rise.
- **Word refill:** `tx_ready` rises the cycle after a load. User logic has until the next word's first load to refill.

## Structure
- **Package `spi_pkg`:** MODE bit positions (CPOL_BIT=1, CPHA_BIT=0), the FSM state enum {WAIT_CS_HIGH, IDLE, SHIFT}, and the sync stage count constant (2).
- **Sub-module `spi_sync_edge`:** 2-FF synchroniser plus rise/fall detector, parameterised by reset value. It is instantiated for `sck` and `cs`; `mosi` uses a plain synchroniser.

## Test plan
1. MODE=0, DATA_W=8, `tx_data`=0xA5 preloaded, master sends 0x3C at SCK=`clk`/8 -> `rx_data`=0x3C with a single `rx_valid` pulse; master captures 0xA5; no underrun.
2. MODE=3, two words in one CS frame (0x12, 0x34); 0x55 preloaded, 0xAA written when `tx_ready` rises -> `rx_valid` twice with 0x12 then 0x34; master captures 0x55, 0xAA.
3. MODE=1, TX buffer empty at CS fall -> `tx_underrun` pulses once; master captures 0x00; `rx_data` correct.
4. MODE=0, `cs` deasserted after 5 bits, then a full frame carrying 0xF0 -> no `rx_valid` for the aborted word; next `rx_data`=0xF0.
5. MODE=2, DATA_W=64, 0x0123456789ABCDEF in both directions -> exact match both ways; `bit_cnt` wraps cleanly.
6. `rst` pulsed after 3 bits with `cs` held low -> all outputs at reset values immediately. The remainder of that frame is ignored (state WAIT_CS_HIGH), and the next frame (0x5A) is received correctly.
